cpu6_memarb: RTL and testbench
==============================

CPU6_MEMARB -- requirements
Module: cpu6_memarb

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter MAXWAIT, default 4, DMA wait cycles before forced DMA grant; range 1..15.
REQ-003 Parameter LOCKMAX, default 8, max consecutive locked DMA beats; range 1..15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 c_req / c_we  input  1 / 1  core access request / write (1) or read (0).
REQ-007 c_addr / c_wdata  input  XLEN / XLEN  core address / write data.
REQ-008 c_gnt  output  1  core access accepted this cycle.
REQ-009 c_rvalid / c_rdata  output  1 / XLEN  core read data valid / read data.
REQ-010 d_req / d_we / d_lock  input  1 / 1 / 1  DMA request / write / hold bus for burst.
REQ-011 d_addr / d_wdata  input  XLEN / XLEN  DMA address / write data.
REQ-012 d_gnt  output  1  DMA access accepted this cycle.
REQ-013 d_rvalid / d_rdata  output  1 / XLEN  DMA read data valid / read data.
REQ-014 mem_en / mem_we  output  1 / 1  RAM port enable / write enable.
REQ-015 mem_addr / mem_wdata  output  XLEN / XLEN  RAM address / write data.
REQ-016 mem_rdata  input  XLEN  RAM read data, valid one cycle after mem_en & ~mem_we.

Function
REQ-017 At most one of c_gnt, d_gnt SHALL be 1 in any cycle; a grant is given only to an active request.
REQ-018 Grants SHALL be combinational from current requests and registered state (same-cycle grant).
REQ-019 mem_en SHALL equal c_gnt|d_gnt; mem_we/addr/wdata SHALL mux from the granted requester; all zero when no grant.
REQ-020 FSM states: ARB, LOCK.
REQ-021 ARB: core wins when c_req and wait_cnt<MAXWAIT; DMA wins when d_req and (~c_req or wait_cnt==MAXWAIT).
REQ-022 ARB->LOCK when d_gnt & d_lock; lock_cnt loads 1.
REQ-023 LOCK: c_gnt=0; d_gnt=d_req; each d_gnt increments lock_cnt.
REQ-024 LOCK->ARB when ~d_req, or ~d_lock (that beat still granted if d_req), or a granted beat brings lock_cnt to LOCKMAX.
REQ-025 After LOCKMAX exit, the next cycle SHALL give core priority regardless of wait_cnt (one-cycle core window) and SHALL NOT re-enter LOCK that cycle.
REQ-026 wait_cnt (4 bit) increments on d_req & ~d_gnt, saturating at MAXWAIT; clears on d_gnt or ~d_req.
REQ-027 Read owner SHALL be registered on each granted read; c_rvalid or d_rvalid pulses exactly one cycle later, to that owner only.
REQ-028 c_rdata/d_rdata SHALL equal mem_rdata while own rvalid is 1, else 0.
REQ-029 Writes SHALL produce no rvalid; back-to-back reads SHALL yield back-to-back rvalid pulses.
REQ-030 No request: no grant, counters hold except wait_cnt clears.

Reset
REQ-031 On reset: state ARB, wait_cnt 0, lock_cnt 0, read owner none, c_rvalid/d_rvalid 0; all grants and mem_* 0 while reset asserted.
REQ-032 Reset mid-read SHALL drop the pending rvalid; reset mid-LOCK SHALL return to ARB.

Verification
REQ-033 c_req=1 read addr 0x100, d_req=0 -> c_gnt=1, mem_addr=0x100 same cycle; next cycle c_rvalid=1, c_rdata=mem_rdata, d_rvalid=0.
REQ-034 c_req and d_req held 1 continuously, MAXWAIT=4 -> c_gnt cycles 0..3, d_gnt cycle 4, wait_cnt back to 0, pattern repeats.
REQ-035 DMA write burst d_lock=1 for 12 beats, c_req=1, LOCKMAX=8 -> d_gnt beats 1..8, then one c_gnt cycle, then DMA regains per ARB rules.
REQ-036 DMA locked, d_lock drops on beat 3 with d_req=1 -> beat 3 granted, next cycle ARB with c_req granted.
REQ-037 Interleaved reads core@0x10, DMA@0x20 consecutive cycles -> c_rvalid then d_rvalid on consecutive cycles, each with its own data.
REQ-038 Assert reset one cycle after granted DMA read -> d_rvalid stays 0, state ARB, counters 0.

Source files
------------

// File: rtl/cpu6_memarb.sv
// Single-port RAM arbiter between a CPU core and a DMA engine.
// Same-cycle grants, DMA starvation guard, bounded locked DMA bursts.
module cpu6_memarb #(
  parameter int XLEN    = 32,
  parameter int MAXWAIT = 4,
  parameter int LOCKMAX = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_c_req,
  input  logic            i_c_we,
  input  logic [XLEN-1:0] i_c_addr,
  input  logic [XLEN-1:0] i_c_wdata,
  output logic            o_c_gnt,
  output logic            o_c_rvalid,
  output logic [XLEN-1:0] o_c_rdata,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic            i_d_lock,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  output logic            o_d_gnt,
  output logic            o_d_rvalid,
  output logic [XLEN-1:0] o_d_rdata,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  localparam logic [3:0] C_MAXWAIT = 4'(MAXWAIT);
  localparam logic [3:0] C_LOCKMAX = 4'(LOCKMAX);

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic [3:0] r_lock_cnt;
  logic       r_core_win;
  logic       r_c_rvalid;
  logic       r_d_rvalid;

  logic       w_core_prio;
  logic       w_c_gnt;
  logic       w_d_gnt;
  logic [3:0] w_lock_next;
  logic       w_lock_full;

  // The core keeps priority until the DMA has waited MAXWAIT cycles,
  // except in the single cycle right after a burst hit LOCKMAX.
  assign w_core_prio = r_core_win | (r_wait_cnt < C_MAXWAIT);
  assign w_lock_next = r_lock_cnt + 4'd1;
  assign w_lock_full = (w_lock_next == C_LOCKMAX);

  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!i_reset) begin
      if (r_state == ST_LOCK) begin
        w_d_gnt = i_d_req;
      end else begin
        w_c_gnt = i_c_req & w_core_prio;
        w_d_gnt = i_d_req & ~w_c_gnt;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_c_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_c_we;
      o_mem_addr  = i_c_addr;
      o_mem_wdata = i_c_wdata;
    end else if (w_d_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_ARB;
      r_wait_cnt <= 4'd0;
      r_lock_cnt <= 4'd0;
      r_core_win <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~i_c_we;
      r_d_rvalid <= w_d_gnt & ~i_d_we;

      if (w_d_gnt || !i_d_req) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt < C_MAXWAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      r_core_win <= 1'b0;
      case (r_state)
        ST_ARB: begin
          // No lock entry during the core window, so the core really gets it.
          if (w_d_gnt && i_d_lock && !r_core_win) begin
            r_lock_cnt <= 4'd1;
            if (LOCKMAX == 1) begin
              r_core_win <= 1'b1;
            end else begin
              r_state <= ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (!i_d_req) begin
            r_state <= ST_ARB;
          end else begin
            r_lock_cnt <= w_lock_next;
            if (w_lock_full) begin
              r_state    <= ST_ARB;
              r_core_win <= 1'b1;
            end else if (!i_d_lock) begin
              r_state <= ST_ARB;
            end
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign o_c_gnt    = w_c_gnt;
  assign o_d_gnt    = w_d_gnt;
  assign o_c_rvalid = r_c_rvalid;
  assign o_d_rvalid = r_d_rvalid;
  assign o_c_rdata  = r_c_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata  = r_d_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_cpu6_memarb.sv
// Bench for cpu6_memarb: directed vector table, reset sequences and random
// traffic, all checked against a rule-level model with a shadow memory.
module tb_cpu6_memarb;
  localparam int XLEN    = 32;
  localparam int MAXWAIT = 4;
  localparam int LOCKMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [XLEN-1:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic            c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [XLEN-1:0] c_rdata, d_rdata;
  logic            mem_en, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata = '0;

  cpu6_memarb #(.XLEN(XLEN), .MAXWAIT(MAXWAIT), .LOCKMAX(LOCKMAX)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_lock(d_lock), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pattern(input int i);
    return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  // RAM attached to the DUT; returns noise when not reading so leaks show up.
  logic [31:0] tb_ram [256];
  logic        ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) tb_ram[i] <= pattern(i);
    end else if (mem_en && mem_we) begin
      tb_ram[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= tb_ram[mem_addr[7:0]];
    else mem_rdata <= $urandom;
  end

  // Reference model state
  logic [31:0] shadow [256];
  bit          m_lock, m_window;
  int          m_wait, m_beats, m_pend;
  logic [31:0] m_pend_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_window = 0; m_wait = 0; m_beats = 0; m_pend = 0; m_pend_data = '0;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      check("rst_gnt_mem", {63'd0, c_gnt, d_gnt, mem_en}, 66'd0);
      check("rst_rvalid", {64'd0, c_rvalid, d_rvalid}, 66'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic step(input logic cr, cw, input logic [31:0] ca, cwd,
                      input logic dr, dw, dl, input logic [31:0] da, dwd,
                      output logic gc, gd);
    logic ec, ed;
    logic [65:0] ebus, ecr, edr;
    bit nw;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    if (m_lock) begin
      ec = 1'b0;
      ed = dr;
    end else begin
      ec = cr && (m_window || m_wait < MAXWAIT);
      ed = dr && !ec;
    end
    ebus = ec ? {1'b1, cw, ca, cwd} : (ed ? {1'b1, dw, da, dwd} : 66'd0);
    ecr  = (m_pend == 1) ? {33'd1, m_pend_data} : 66'd0;
    edr  = (m_pend == 2) ? {33'd1, m_pend_data} : 66'd0;
    check("grant", {64'd0, c_gnt, d_gnt}, {64'd0, ec, ed});
    check("mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, ebus);
    check("core_read", {33'd0, c_rvalid, c_rdata}, ecr);
    check("dma_read", {33'd0, d_rvalid, d_rdata}, edr);
    gc = c_gnt;
    gd = d_gnt;
    m_pend = 0;
    if (ec) begin
      if (cw) shadow[ca[7:0]] = cwd;
      else begin m_pend = 1; m_pend_data = shadow[ca[7:0]]; end
    end
    if (ed) begin
      if (dw) shadow[da[7:0]] = dwd;
      else begin m_pend = 2; m_pend_data = shadow[da[7:0]]; end
    end
    if (ed || !dr) m_wait = 0;
    else if (m_wait < MAXWAIT) m_wait++;
    nw = 0;
    if (m_lock) begin
      if (!dr) m_lock = 0;
      else begin
        m_beats++;
        if (m_beats == LOCKMAX) begin m_lock = 0; nw = 1; end
        else if (!dl) m_lock = 0;
      end
    end else if (ed && dl && !m_window) begin
      m_lock = 1;
      m_beats = 1;
    end
    m_window = nw;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic cr, cw; logic [31:0] ca, cwd;
    logic dr, dw, dl; logic [31:0] da, dwd;
    logic ec, ed;
  } vec_t;

  function automatic vec_t v(input logic cr, cw, input logic [31:0] ca, cwd,
                             input logic dr, dw, dl, input logic [31:0] da, dwd,
                             input logic ec, ed);
    vec_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cwd = cwd;
    r.dr = dr; r.dw = dw; r.dl = dl; r.da = da; r.dwd = dwd;
    r.ec = ec; r.ed = ed;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    logic gc, gd;

    for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
    model_reset();

    // Directed table: grant expectations written out by hand.
    tbl.push_back(v(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(1, 0, 32'h40 + i, 0, 1, 0, 0, 32'h80 + i, 0, (i % 5) != 4, (i % 5) == 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'h200, 32'hD0000000, 0, 1));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(v(1, 0, 32'h30, 0, 1, 1, 1, 32'h200 + k, 32'hD0000000 + k, 0, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(1, 0, 32'h200 + k, 0, 1, 1, 1, 32'h240, 32'hE0000000, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(1, 0, 32'h31, 0, 1, 1, 1, 32'h250 + k, 32'hE1000000 + k, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'h210, 32'hB1, 0, 1));
    tbl.push_back(v(1, 0, 32'h44, 0, 1, 1, 1, 32'h211, 32'hB2, 0, 1));
    tbl.push_back(v(1, 0, 32'h44, 0, 1, 1, 0, 32'h212, 32'hB3, 0, 1));
    tbl.push_back(v(1, 0, 32'h44, 0, 1, 0, 0, 32'h213, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, 0, 1));
    tbl.push_back(v(1, 1, 32'h10, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset(3);
    ram_init = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cwd, tbl[i].dr, tbl[i].dw, tbl[i].dl,
           tbl[i].da, tbl[i].dwd, gc, gd);
      check($sformatf("table_gnt[%0d]", i), {64'd0, gc, gd}, {64'd0, tbl[i].ec, tbl[i].ed});
    end

    // Reset arriving while a granted DMA read awaits its data.
    c_req = 0; d_req = 1; d_we = 0; d_lock = 0; d_addr = 32'h30;
    @(negedge clk);
    check("rst_mid_read_gnt", {65'd0, d_gnt}, 66'd1);
    #1;
    do_reset(1);
    step(1, 0, 32'h33, 0, 1, 0, 1, 32'h34, 0, gc, gd);
    check("after_rst_core_first", {64'd0, gc, gd}, 66'd2);

    // Reset in the middle of a locked burst.
    step(0, 0, 0, 0, 1, 1, 1, 32'h60, 32'h1, gc, gd);
    step(1, 0, 32'h61, 0, 1, 1, 1, 32'h62, 32'h2, gc, gd);
    check("lock_holds_core_off", {64'd0, gc, gd}, 66'd1);
    do_reset(2);
    step(1, 0, 32'h63, 0, 1, 1, 1, 32'h64, 32'h3, gc, gd);
    check("lock_cleared_by_rst", {64'd0, gc, gd}, 66'd2);

    // Random traffic, biased toward contention and long locked bursts.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset(1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) != 0,
           $urandom, $urandom, gc, gd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
